xs3_bcd_codec: RTL and testbench

Multi-digit, parametrised excess-3/BCD code converter with per-digit validity checking. It accepts one packed word of DIGITS 4-bit digits over a valid/ready handshake and converts it in either direction, excess-3 to BCD or BCD to excess-3. A small FSM processes one digit per clock, least-significant digit first, then holds the result until the consumer takes it. It sits between digit-serial display/arithmetic stages and code-domain interfaces, replacing single-digit combinational converters.

---
 rtl/xs3_bcd_codec_if.sv | 25 ++
 rtl/xs3_bcd_codec.sv | 108 ++++++++++
 tb/tb_xs3_bcd_codec.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/xs3_bcd_codec_if.sv
// Handshake bundle for xs3_bcd_codec: word input channel and result output channel.
// The producer/consumer side uses master; the codec uses slave.
interface xs3_bcd_codec_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_mode;
    logic [4*DIGITS-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_data;
    logic [DIGITS-1:0]     out_err_mask;
    logic                  out_err;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err_mask, out_err
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err_mask, out_err
    );
endinterface

// File: rtl/xs3_bcd_codec.sv
// Digit-serial excess-3 <-> BCD converter with per-digit invalid-code flags.
// state | meaning
// IDLE  | ready for a word; in_ready high
// CONV  | converting digit idx of the latched word, LSD first
// DONE  | result held with out_valid until out_ready
module xs3_bcd_codec #(
    parameter int DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    xs3_bcd_codec_if.slave     bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q;
    logic                  mode_q;
    logic [4*DIGITS-1:0]   data_q;
    logic [4*DIGITS-1:0]   res_q;
    logic [DIGITS-1:0]     err_q;
    logic                  out_valid_q;

    logic                  accept;
    logic                  conv_en;
    logic                  release_word;
    logic                  ready_c;
    logic [3:0]            cur_dig;
    logic [3:0]            res_dig;
    logic                  dig_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)   state_d = CONV;
            CONV:    if (idx_q == LAST)  state_d = DONE;
            DONE:    if (bus.out_ready)  state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_c      = (state_q == IDLE);
        accept       = ready_c && bus.in_valid;
        conv_en      = (state_q == CONV);
        release_word = (state_q == DONE) && bus.out_ready;
    end

    always_comb begin
        cur_dig = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) cur_dig = data_q[4*i +: 4];
        end
    end

    // Out-of-range codes map to 4'hF so a bad digit never aliases a legal one.
    always_comb begin
        if (!mode_q) begin
            dig_ok  = (cur_dig >= 4'h3) && (cur_dig <= 4'hC);
            res_dig = cur_dig - 4'h3;
        end else begin
            dig_ok  = (cur_dig <= 4'h9);
            res_dig = cur_dig + 4'h3;
        end
        if (!dig_ok) res_dig = 4'hF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            mode_q      <= 1'b0;
            data_q      <= '0;
            res_q       <= '0;
            err_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            data_q <= bus.in_data;
            mode_q <= bus.in_mode;
            res_q  <= '0;
            err_q  <= '0;
            idx_q  <= '0;
        end else if (conv_en) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx_q == IW'(i)) begin
                    res_q[4*i +: 4] <= res_dig;
                    err_q[i]        <= ~dig_ok;
                end
            end
            idx_q <= idx_q + IW'(1);
            if (idx_q == LAST) out_valid_q <= 1'b1;
        end else if (release_word) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready     = ready_c;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = res_q;
    assign bus.out_err_mask = err_q;
    assign bus.out_err      = |err_q;
endmodule

// File: tb/tb_xs3_bcd_codec.sv
// Self-checking bench for xs3_bcd_codec: directed vectors, handshake/reset
// corner cases, exhaustive per-position codes and random words vs. a model.
module tb_xs3_bcd_codec;
    localparam int D = 4;
    localparam int W = 4 * D;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    xs3_bcd_codec_if #(.DIGITS(D)) bus ();

    xs3_bcd_codec #(.DIGITS(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic           mode;
        logic [W-1:0]   din;
        logic [W-1:0]   dout;
        logic [D-1:0]   mask;
    } vec_t;

    vec_t vt[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: per-digit arithmetic on integers, invalid codes -> F.
    function automatic logic [W+D-1:0] model(input logic m, input logic [W-1:0] d);
        logic [W-1:0] r;
        logic [D-1:0] e;
        int c;
        bit ok;
        int v;
        r = '0;
        e = '0;
        for (int i = 0; i < D; i++) begin
            c = int'(d[4*i +: 4]);
            if (m == 1'b0) begin ok = (c >= 3 && c <= 12); v = c - 3; end
            else           begin ok = (c <= 9);            v = c + 3; end
            r[4*i +: 4] = ok ? 4'(v) : 4'hF;
            e[i] = !ok;
        end
        return {e, r};
    endfunction

    task automatic start_word(input logic m, input logic [W-1:0] d, input bit toggle, output int lat);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("ready_before_accept", 64'(bus.in_ready), 64'd1);
        bus.in_mode  = m;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            if (toggle) begin
                bus.in_mode = ~bus.in_mode;
                bus.in_data = W'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        lat = n;
    endtask

    task automatic finish_word(input logic [W-1:0] ed, input logic [D-1:0] em);
        chk("out_valid", 64'(bus.out_valid), 64'd1);
        chk("out_data", 64'(bus.out_data), 64'(ed));
        chk("out_err_mask", 64'(bus.out_err_mask), 64'(em));
        chk("out_err", 64'(bus.out_err), 64'(|em));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("release_valid", 64'(bus.out_valid), 64'd0);
        chk("release_ready", 64'(bus.in_ready), 64'd1);
        chk("release_hold", 64'(bus.out_data), 64'(ed));
    endtask

    task automatic run_word(input logic m, input logic [W-1:0] d, input logic [W-1:0] ed,
                            input logic [D-1:0] em, input bit toggle);
        int lat;
        start_word(m, d, toggle, lat);
        chk("latency", 64'(lat), 64'(D));
        finish_word(ed, em);
    endtask

    initial begin
        logic [W+D-1:0] exp;
        logic [W-1:0]   d;
        logic           m;
        int             lat;

        vt[0] = '{mode: 1'b0, din: 16'h4C73, dout: 16'h1940, mask: 4'b0000};
        vt[1] = '{mode: 1'b1, din: 16'h1940, dout: 16'h4C73, mask: 4'b0000};
        vt[2] = '{mode: 1'b0, din: 16'h3D02, dout: 16'h0FFF, mask: 4'b0111};
        vt[3] = '{mode: 1'b1, din: 16'hA009, dout: 16'hF33C, mask: 4'b1000};

        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_mask", 64'(bus.out_err_mask), 64'd0);
        chk("rst_err", 64'(bus.out_err), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed table; vector 1 also toggles mode/data during CONV.
        for (int k = 0; k < 4; k++)
            run_word(vt[k].mode, vt[k].din, vt[k].dout, vt[k].mask, k == 1);

        // Held result with a pending word that must wait for release.
        start_word(1'b0, 16'h4C73, 1'b0, lat);
        chk("hold_latency", 64'(lat), 64'(D));
        bus.in_mode  = 1'b1;
        bus.in_data  = 16'h1940;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_data", 64'(bus.out_data), 64'h1940);
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("hold_release_ready", 64'(bus.in_ready), 64'd1);
        chk("hold_release_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("pending_accepted", 64'(bus.in_ready), 64'd0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("pending_latency", 64'(lat), 64'(D));
        finish_word(16'h4C73, 4'b0000);

        // Asynchronous reset two cycles into CONV.
        bus.in_mode  = 1'b0;
        bus.in_data  = 16'h4C73;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_out_data", 64'(bus.out_data), 64'd0);
        chk("arst_mask", 64'(bus.out_err_mask), 64'd0);
        chk("arst_err", 64'(bus.out_err), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_word(1'b1, 16'h0287, 16'h35BA, 4'b0000, 1'b0);

        // Every code at every digit position, both modes.
        for (int b = 0; b < 16; b++) begin
            for (int mm = 0; mm < 2; mm++) begin
                for (int i = 0; i < D; i++) d[4*i +: 4] = 4'(b + i);
                m = 1'(mm);
                exp = model(m, d);
                run_word(m, d, exp[W-1:0], exp[W+D-1:W], 1'b0);
            end
        end

        for (int r = 0; r < 40; r++) begin
            d = W'($urandom);
            m = 1'($urandom_range(0, 1));
            exp = model(m, d);
            run_word(m, d, exp[W-1:0], exp[W+D-1:W], 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
